cpu_boot_loader: RTL and testbench
==================================

Name: cpu_boot_loader

Overview:
- Byte-stream program loader sitting directly upstream of the cpu top.
- Parses a simple command protocol from a host byte interface (valid/ready).
- Assembles 32-bit words and drives the cpu external instruction-memory port (addr_ext/wen_ext/wdata_ext) and data-memory port (addr_ext_2/wen_ext_2/wdata_ext_2).
- Then raises the cpu enable to start execution.

Parameters:
- DATA_W, 32, width of memory words and ext data/address buses
- CNT_W, 16, width of start-index and word-count fields

Ports:
- clk  input  1  main clock
- arst  input  1  asynchronous reset, active-high
- in_valid  input  1  host byte valid
- in_data  input  8  host byte
- in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
- addr_ext  output  DATA_W  instruction-memory ext address (byte address)
- wen_ext  output  1  instruction-memory ext write enable, one-cycle pulse
- ren_ext  output  1  tied 0
- wdata_ext  output  DATA_W  instruction-memory ext write word
- addr_ext_2  output  DATA_W  data-memory ext address (byte address)
- wen_ext_2  output  1  data-memory ext write enable, one-cycle pulse
- ren_ext_2  output  1  tied 0
- wdata_ext_2  output  DATA_W  data-memory ext write word
- cpu_enable  output  1  drives cpu enable
- busy  output  1  high in any state other than IDLE/ERR
- error  output  1  sticky protocol error flag

Behaviour:
- Reset (arst high, async): state IDLE; in_ready=1; all wen/ren=0; addr/wdata=0; cpu_enable=0; busy=0; error=0.
- Command bytes, accepted in IDLE:
  - 0x01 = LOAD_IMEM
  - 0x02 = LOAD_DMEM
  - 0x03 = RUN: cpu_enable<=1 next cycle
  - 0x04 = HALT: cpu_enable<=0 next cycle
  - 0x00 = NOP
  - any other value -> ERR
- LOAD while cpu_enable=1 -> ERR; cpu_enable is unchanged.
- LOAD frame, all fields big-endian: cmd, IDX_HI, IDX_LO, CNT_HI, CNT_LO, then CNT×4 data bytes.
  - Word byte order: first byte = bits [31:24].
- FSM: IDLE -> IDX_HI -> IDX_LO -> CNT_HI -> CNT_LO -> DATA (byte counter 0..3) -> WRITE -> DATA or DONE -> IDLE.
- WRITE:
  - Lasts exactly one cycle; in_ready=0.
  - Exactly one of wen_ext/wen_ext_2 is high, per the latched target.
  - addr = {idx, 2'b00} zero-extended to DATA_W; wdata = the assembled word.
  - addr/wdata are registered and held stable until the next WRITE.
  - idx increments, wrapping 0xFFFF -> 0x0000; remaining count decrements.
- Latency: the write pulse occurs the cycle after the 4th byte of a word is accepted.
- in_ready=1 in IDLE, IDX/CNT/DATA and ERR states; 0 in WRITE.
- CNT=0: after CNT_LO, go straight to DONE (no writes).
- in_valid low in any state: hold state; no timeout.
- ERR: error=1, busy=0, in_ready=1.
  - Bytes are consumed and ignored; byte 0xFF clears error and returns to IDLE.
  - cpu_enable is retained.
- arst mid-frame: immediate return to reset values; a partial word is discarded and never written.

Optional Feature:
- BOOT_CHECKSUM_EN defined:
  - A LOAD frame carries one extra byte after the data: XOR of all data bytes (0x00 when CNT=0).
  - State CSUM is inserted before DONE.
  - Mismatch -> ERR; words already written remain in memory.
- Undefined: no checksum byte; DONE follows the last WRITE directly.

Test Plan:
- Reset then stream 01 00 02 00 01 DE AD BE EF -> single wen_ext pulse, addr_ext=0x8, wdata_ext=0xDEADBEEF; busy falls; error=0.
- Stream 02 FF FF 00 02 + 8 bytes 11 22 33 44 55 66 77 88 -> wen_ext_2 pulses at addr 0x3FFFC (0x11223344), then addr 0x0 (0x55667788) showing wrap; wen_ext never high.
- Send 03 then 01 -> cpu_enable=1 one cycle after 03; 01 causes error=1, cpu_enable stays 1; byte FF clears error; 04 drops cpu_enable.
- Drive in_valid with a random gap pattern during a 3-word IMEM load -> identical write sequence to the gap-free load; in_ready=0 exactly on each WRITE cycle.
- Assert arst after 2 data bytes of a word -> no wen pulse; all outputs at reset values; a subsequent clean frame loads correctly.
- (BOOT_CHECKSUM_EN) Frame 01 00 00 00 01 01 02 03 04 04 -> write 0x01020304, no error; the same frame with checksum 05 -> write occurs, then error=1.

Source files
------------

// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader
//   Byte-stream program loader placed in front of the cpu top. A host pushes
//   command bytes over a valid/ready byte interface; LOAD frames are assembled
//   into 32-bit big-endian words and written through the cpu external
//   instruction-memory or data-memory port. RUN/HALT drive the cpu enable.
//
//   Optional build macro: BOOT_CHECKSUM_EN
//     When defined, each LOAD frame ends with one XOR checksum byte over all
//     data bytes. A mismatch enters ERR; words already written stay written.
//
// Ports
//   clk                 main clock
//   arst                asynchronous reset, active-high
//   in_valid/in_data    host byte stream
//   in_ready            byte accepted this cycle when in_valid & in_ready
//   addr_ext/wen_ext/wdata_ext/ren_ext          instruction-memory ext port
//   addr_ext_2/wen_ext_2/wdata_ext_2/ren_ext_2  data-memory ext port
//   cpu_enable          cpu run enable
//   busy                frame in progress (any state other than IDLE/ERR)
//   error               sticky protocol error, cleared by byte 0xFF in ERR
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a command byte
// IDX_HI   | receiving start word index, high byte
// IDX_LO   | receiving start word index, low byte
// CNT_HI   | receiving word count, high byte
// CNT_LO   | receiving word count, low byte
// DATA     | receiving the 4 bytes of a word (byte_cnt 0..3)
// WRITE    | one-cycle write pulse on the selected memory port
// CSUM     | receiving the frame checksum byte (BOOT_CHECKSUM_EN only)
// DONE     | frame complete; also decodes a command byte like IDLE
// ERR      | protocol error; bytes ignored until 0xFF
module cpu_boot_loader #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] addr_ext,
   output logic              wen_ext,
   output logic              ren_ext,
   output logic [DATA_W-1:0] wdata_ext,
   output logic [DATA_W-1:0] addr_ext_2,
   output logic              wen_ext_2,
   output logic              ren_ext_2,
   output logic [DATA_W-1:0] wdata_ext_2,
   output logic              cpu_enable,
   output logic              busy,
   output logic              error
);

   typedef enum logic [3:0] {
      S_IDLE, S_IDX_HI, S_IDX_LO, S_CNT_HI, S_CNT_LO,
      S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
   } state_t;

   localparam logic [7:0] CMD_NOP   = 8'h00;
   localparam logic [7:0] CMD_LDI   = 8'h01;
   localparam logic [7:0] CMD_LDD   = 8'h02;
   localparam logic [7:0] CMD_RUN   = 8'h03;
   localparam logic [7:0] CMD_HALT  = 8'h04;
   localparam logic [7:0] ERR_CLEAR = 8'hFF;

   state_t              state;
   logic                tgt_dmem;
   logic [CNT_W-1:0]    idx;
   logic [CNT_W-1:0]    cnt;
   logic [1:0]          byte_cnt;
   logic [DATA_W-9:0]   word;       // first three bytes of the word in flight
   logic [DATA_W-1:0]   word_addr;
   logic [CNT_W-1:0]    cnt_next;
   logic                take;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]          csum;
`endif

   assign take      = in_valid & in_ready;
   assign word_addr = {{(DATA_W-CNT_W-2){1'b0}}, idx, 2'b00};
   assign cnt_next  = {cnt[CNT_W-9:0], in_data};
   assign ren_ext   = 1'b0;
   assign ren_ext_2 = 1'b0;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state       <= S_IDLE;
         in_ready    <= 1'b1;
         addr_ext    <= '0;
         wen_ext     <= 1'b0;
         wdata_ext   <= '0;
         addr_ext_2  <= '0;
         wen_ext_2   <= 1'b0;
         wdata_ext_2 <= '0;
         cpu_enable  <= 1'b0;
         busy        <= 1'b0;
         error       <= 1'b0;
         tgt_dmem    <= 1'b0;
         idx         <= '0;
         cnt         <= '0;
         byte_cnt    <= '0;
         word        <= '0;
`ifdef BOOT_CHECKSUM_EN
         csum        <= '0;
`endif
      end else begin
         wen_ext   <= 1'b0;
         wen_ext_2 <= 1'b0;
         case (state)
            // DONE decodes commands too, so a byte offered right after a
            // frame is never silently dropped while in_ready is high.
            S_IDLE, S_DONE: begin
               if (take) begin
                  case (in_data)
                     CMD_NOP: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end
                     CMD_LDI, CMD_LDD: begin
                        if (cpu_enable) begin
                           state <= S_ERR;
                           error <= 1'b1;
                           busy  <= 1'b0;
                        end else begin
                           tgt_dmem <= (in_data == CMD_LDD);
                           state    <= S_IDX_HI;
                           busy     <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
                           csum     <= '0;
`endif
                        end
                     end
                     CMD_RUN: begin
                        cpu_enable <= 1'b1;
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                     end
                     CMD_HALT: begin
                        cpu_enable <= 1'b0;
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                     end
                     default: begin
                        state <= S_ERR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                     end
                  endcase
               end else if (state == S_DONE) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_IDX_HI: if (take) begin
               idx   <= CNT_W'(in_data);
               state <= S_IDX_LO;
            end
            S_IDX_LO: if (take) begin
               idx   <= {idx[CNT_W-9:0], in_data};
               state <= S_CNT_HI;
            end
            S_CNT_HI: if (take) begin
               cnt   <= CNT_W'(in_data);
               state <= S_CNT_LO;
            end
            S_CNT_LO: if (take) begin
               cnt      <= cnt_next;
               byte_cnt <= '0;
               if (cnt_next == '0) begin
`ifdef BOOT_CHECKSUM_EN
                  state <= S_CSUM;
`else
                  state <= S_DONE;
`endif
               end else begin
                  state <= S_DATA;
               end
            end
            S_DATA: if (take) begin
               word     <= {word[DATA_W-17:0], in_data};
               byte_cnt <= byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
               csum     <= csum ^ in_data;
`endif
               if (byte_cnt == 2'd3) begin
                  state    <= S_WRITE;
                  in_ready <= 1'b0;
                  if (tgt_dmem) begin
                     wen_ext_2   <= 1'b1;
                     addr_ext_2  <= word_addr;
                     wdata_ext_2 <= {word, in_data};
                  end else begin
                     wen_ext     <= 1'b1;
                     addr_ext    <= word_addr;
                     wdata_ext   <= {word, in_data};
                  end
               end
            end
            S_WRITE: begin
               in_ready <= 1'b1;
               idx      <= idx + 1'b1;
               cnt      <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
`ifdef BOOT_CHECKSUM_EN
                  state <= S_CSUM;
`else
                  state <= S_DONE;
`endif
               end else begin
                  state <= S_DATA;
               end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: if (take) begin
               if (in_data == csum) begin
                  state <= S_DONE;
               end else begin
                  state <= S_ERR;
                  error <= 1'b1;
                  busy  <= 1'b0;
               end
            end
`endif
            S_ERR: if (take && in_data == ERR_CLEAR) begin
               state <= S_IDLE;
               error <= 1'b0;
            end
            default: begin
               state    <= S_IDLE;
               busy     <= 1'b0;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_boot_loader.sv
module tb_cpu_boot_loader;

   logic        clk = 1'b0;
   logic        arst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
   logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
   logic        cpu_enable, busy, error;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] ia[$], id[$], da[$], dd[$];
   int          ready_low = 0;
   int          ready_bad = 0;
   logic [7:0]  frm[$];
   logic [7:0]  dq[$];
   int          gap_pat[8] = '{0, 2, 1, 3, 0, 1, 4, 2};

   cpu_boot_loader #(.DATA_W(32), .CNT_W(16)) dut (
      .clk(clk), .arst(arst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .wdata_ext_2(wdata_ext_2),
      .cpu_enable(cpu_enable), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   // Write and handshake monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (!arst) begin
         if (wen_ext)   begin ia.push_back(addr_ext);   id.push_back(wdata_ext);   end
         if (wen_ext_2) begin da.push_back(addr_ext_2); dd.push_back(wdata_ext_2); end
         if (!in_ready) ready_low++;
         if (in_ready === (wen_ext | wen_ext_2)) ready_bad++;
         if (wen_ext && wen_ext_2) ready_bad++;
         if (ren_ext || ren_ext_2) ready_bad++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      ia.delete(); id.delete(); da.delete(); dd.delete();
      ready_low = 0;
   endtask

   task automatic send(input logic [7:0] b);
      int k;
      k = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         n_fail++;
         $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high byte=%0h", b);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < frm.size(); i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat (gap_pat[i % 8]) @(posedge clk);
            #1;
         end
         send(frm[i]);
      end
   endtask

   // Builds cmd/idx/cnt header plus the bytes in dq; appends the XOR
   // checksum when the checksum feature is compiled in.
   task automatic build_load(input logic [7:0] cmd, input logic [15:0] idx,
                             input logic [15:0] cnt);
      logic [7:0] x;
      x = 8'h00;
      frm.delete();
      frm.push_back(cmd);
      frm.push_back(idx[15:8]); frm.push_back(idx[7:0]);
      frm.push_back(cnt[15:8]); frm.push_back(cnt[7:0]);
      foreach (dq[i]) begin
         frm.push_back(dq[i]);
         x = x ^ dq[i];
      end
`ifdef BOOT_CHECKSUM_EN
      frm.push_back(x);
`endif
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, in_ready, 1'b1);
      check({tag, "_outs"}, {wen_ext, wen_ext_2, ren_ext, ren_ext_2, cpu_enable, busy, error}, 7'b0);
      check({tag, "_addr"}, {addr_ext, addr_ext_2}, 64'h0);
      check({tag, "_wdata"}, {wdata_ext, wdata_ext_2}, 64'h0);
   endtask

   initial begin
      arst     = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      arst = 1'b0;
      @(posedge clk); #1;

      // Single IMEM word at index 2.
      clear_log();
      dq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      build_load(8'h01, 16'h0002, 16'h0001);
      send_frame(1'b0);
      check("imem1_wen_now", wen_ext, 1'b1);
      check("imem1_ready_now", in_ready, 1'b0);
      settle();
      check("imem1_nwr", ia.size(), 1);
      check("imem1_addr", (ia.size() > 0) ? ia[0] : 32'hx, 32'h8);
      check("imem1_data", (id.size() > 0) ? id[0] : 32'hx, 32'hDEADBEEF);
      check("imem1_dmem_nwr", da.size(), 0);
      check("imem1_hold", {addr_ext, wdata_ext}, {32'h8, 32'hDEADBEEF});
      check("imem1_busy_err", {busy, error}, 2'b00);

      // DMEM two words, index wraps 0xFFFF -> 0x0000.
      clear_log();
      dq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      build_load(8'h02, 16'hFFFF, 16'h0002);
      send_frame(1'b0);
      settle();
      check("dmem_nwr", da.size(), 2);
      check("dmem_addr0", (da.size() > 0) ? da[0] : 32'hx, 32'h0003FFFC);
      check("dmem_data0", (dd.size() > 0) ? dd[0] : 32'hx, 32'h11223344);
      check("dmem_addr1", (da.size() > 1) ? da[1] : 32'hx, 32'h0);
      check("dmem_data1", (dd.size() > 1) ? dd[1] : 32'hx, 32'h55667788);
      check("dmem_imem_nwr", ia.size(), 0);
      check("dmem_imem_hold", {addr_ext, wdata_ext}, {32'h8, 32'hDEADBEEF});

      // RUN, LOAD while running, error clear, HALT.
      send(8'h03);
      check("run_en", cpu_enable, 1'b1);
      check("run_busy", busy, 1'b0);
      send(8'h01);
      check("ld_running_err", {error, cpu_enable, busy, in_ready}, 4'b1101);
      send(8'h05);
      check("err_ignore", error, 1'b1);
      send(8'hFF);
      check("err_clear", {error, cpu_enable}, 2'b01);
      send(8'h04);
      check("halt_en", cpu_enable, 1'b0);

      // Unknown command.
      send(8'h07);
      check("bad_cmd_err", {error, busy}, 2'b10);
      send(8'hFF);
      check("bad_cmd_clear", error, 1'b0);

      // NOP and CNT=0 frame produce no writes.
      clear_log();
      send(8'h00);
      check("nop_busy", busy, 1'b0);
      dq.delete();
      build_load(8'h01, 16'h0123, 16'h0000);
      send_frame(1'b0);
      settle();
      check("cnt0_nwr", ia.size() + da.size(), 0);
      check("cnt0_busy_err", {busy, error}, 2'b00);

      // Three-word IMEM load, gap-free then with in_valid gaps.
      dq = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
             8'hA5, 8'h5A, 8'hC3, 8'h3C};
      build_load(8'h01, 16'h0010, 16'h0003);
      for (int run = 0; run < 2; run++) begin
         clear_log();
         send_frame(run == 1);
         settle();
         check("gap_nwr", ia.size(), 3);
         check("gap_addr0", (ia.size() > 0) ? ia[0] : 32'hx, 32'h40);
         check("gap_data0", (id.size() > 0) ? id[0] : 32'hx, 32'h01234567);
         check("gap_addr1", (ia.size() > 1) ? ia[1] : 32'hx, 32'h44);
         check("gap_data1", (id.size() > 1) ? id[1] : 32'hx, 32'h89ABCDEF);
         check("gap_addr2", (ia.size() > 2) ? ia[2] : 32'hx, 32'h48);
         check("gap_data2", (id.size() > 2) ? id[2] : 32'hx, 32'hA55AC33C);
         check("gap_ready_low", ready_low, 3);
      end

      // Stall in the header: state and outputs hold.
      send(8'h01);
      send(8'h00);
      repeat (6) @(posedge clk); #1;
      check("stall_busy_ready", {busy, in_ready, error}, 3'b110);
      clear_log();
      frm = '{8'h03, 8'h00, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40};
`ifdef BOOT_CHECKSUM_EN
      frm.push_back(8'h40);
`endif
      send_frame(1'b0);
      settle();
      check("stall_addr", (ia.size() == 1) ? ia[0] : 32'hx, 32'hC);
      check("stall_data", (id.size() == 1) ? id[0] : 32'hx, 32'h10203040);

      // Reset in the middle of a word.
      clear_log();
      frm = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h01, 8'hAA, 8'hBB};
      send_frame(1'b0);
      check("mid_busy", busy, 1'b1);
      arst = 1'b1;
      #1;
      check_reset_vals("mid_rst");
      repeat (2) @(negedge clk);
      arst = 1'b0;
      @(posedge clk); #1;
      check("mid_nwr", ia.size() + da.size(), 0);
      dq = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
      build_load(8'h01, 16'h0005, 16'h0001);
      send_frame(1'b0);
      settle();
      check("post_rst_nwr", ia.size(), 1);
      check("post_rst_addr", (ia.size() > 0) ? ia[0] : 32'hx, 32'h14);
      check("post_rst_data", (id.size() > 0) ? id[0] : 32'hx, 32'hCAFEBABE);

`ifdef BOOT_CHECKSUM_EN
      clear_log();
      frm = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      send_frame(1'b0);
      settle();
      check("csum_ok_data", (id.size() == 1) ? id[0] : 32'hx, 32'h01020304);
      check("csum_ok_err", error, 1'b0);
      clear_log();
      frm = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send_frame(1'b0);
      settle();
      check("csum_bad_nwr", ia.size(), 1);
      check("csum_bad_err", {error, busy}, 2'b10);
      send(8'hFF);
      check("csum_bad_clear", error, 1'b0);
`endif

      check("handshake_consistency", ready_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
